keypad_loader: RTL and testbench

Digit-entry and load sequencer for the microwave cook timer. Captures keypad digits into a three-digit M:SS entry buffer, validates the entry on Start, and drives the timer's serial load interface (`data`/`loadn`) followed by the count enable (`en`). Handles pause, resume and cancel, and flags completion when the timer reports `zero`. Sits between the keypad scanner and the timer; its outputs connect directly to the timer's load/enable pins.

---
 rtl/keypad_loader.sv | 172 +++++++++++++++++
 tb/tb_keypad_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/keypad_loader.sv
// keypad_loader
//   Digit-entry and load sequencer for the microwave cook timer. Collects
//   keypad digits into an M:SS entry buffer, validates the entry on Start,
//   serially loads the timer (mins, tens, ones on data/loadn), then enables
//   counting. Handles pause/resume/cancel and flags completion on zero.
//
// Parameters
//   DONE_CYCLES  cycles that done stays high after the timer reaches zero (>=1)
//
// Ports
//   clock        in   system clock, rising edge
//   clear        in   synchronous active-high reset
//   key_valid    in   one-cycle key strobe
//   key_code     in   0-9 digit, 10 Start, 11 Stop/Cancel, 12-15 ignored
//   door_closed  in   1 = door closed
//   zero         in   timer at 0:00
//   data         out  digit presented to the timer during load
//   loadn        out  active-low timer load
//   en           out  timer count enable
//   entry_mins/tens/ones  out  entry buffer for the display
//   cooking      out  high while running
//   done         out  high for DONE_CYCLES cycles after completion
//   err          out  one-cycle pulse on a rejected Start
module keypad_loader #(
  parameter int DONE_CYCLES = 3
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       door_closed,
  input  logic       zero,
  output logic [3:0] data,
  output logic       loadn,
  output logic       en,
  output logic [3:0] entry_mins,
  output logic [3:0] entry_tens,
  output logic [3:0] entry_ones,
  output logic       cooking,
  output logic       done,
  output logic       err
);

  localparam int CW = (DONE_CYCLES < 2) ? 1 : $clog2(DONE_CYCLES + 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_M  = 3'd1,
    LOAD_T  = 3'd2,
    LOAD_O  = 3'd3,
    RUN     = 3'd4,
    PAUSED  = 3'd5,
    DONE_ST = 3'd6
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [3:0]     mins_nx, tens_nx, ones_nx;
  logic [3:0]     data_nx;
  logic           err_nx;
  logic           is_digit, is_start, is_stop;

  // A Start is accepted only for a non-zero entry with a legal tens-of-seconds
  // digit and the door shut.
  function automatic logic start_ok(input logic [3:0] m, input logic [3:0] t,
                                    input logic [3:0] o, input logic door);
    return door && (t <= 4'd5) && ({m, t, o} != 12'd0);
  endfunction

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_start = key_valid && (key_code == 4'd10);
  assign is_stop  = key_valid && (key_code == 4'd11);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mins_nx  = entry_mins;
    tens_nx  = entry_tens;
    ones_nx  = entry_ones;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (is_digit) begin
          mins_nx = entry_tens;
          tens_nx = entry_ones;
          ones_nx = key_code;
        end else if (is_start) begin
          if (start_ok(entry_mins, entry_tens, entry_ones, door_closed))
            state_nx = LOAD_M;
          else
            err_nx = 1'b1;
        end else if (is_stop) begin
          mins_nx = 4'd0;
          tens_nx = 4'd0;
          ones_nx = 4'd0;
        end
      end
      LOAD_M: state_nx = LOAD_T;
      LOAD_T: state_nx = LOAD_O;
      LOAD_O: state_nx = RUN;
      RUN: begin
        // zero outranks Stop and door-open; door-open outranks Start
        if (zero) begin
          state_nx = DONE_ST;
          cnt_nx   = CW'(1);
        end else if (is_stop || !door_closed) begin
          state_nx = PAUSED;
        end
      end
      PAUSED: begin
        if (is_start && door_closed) begin
          state_nx = RUN;
        end else if (is_stop) begin
          state_nx = IDLE;
          mins_nx  = 4'd0;
          tens_nx  = 4'd0;
          ones_nx  = 4'd0;
        end
      end
      DONE_ST: begin
        if (cnt == DONE_LAST) begin
          state_nx = IDLE;
          mins_nx  = 4'd0;
          tens_nx  = 4'd0;
          ones_nx  = 4'd0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Entry is frozen throughout loading, so the current buffer is what goes out.
    case (state_nx)
      LOAD_M:  data_nx = entry_mins;
      LOAD_T:  data_nx = entry_tens;
      LOAD_O:  data_nx = entry_ones;
      default: data_nx = 4'd0;
    endcase
  end

  // Output register stage: every output is a flop fed from the next-state decode.
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      entry_mins <= 4'd0;
      entry_tens <= 4'd0;
      entry_ones <= 4'd0;
      data       <= 4'd0;
      loadn      <= 1'b1;
      en         <= 1'b0;
      cooking    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      entry_mins <= mins_nx;
      entry_tens <= tens_nx;
      entry_ones <= ones_nx;
      data       <= data_nx;
      loadn      <= !(state_nx == LOAD_M || state_nx == LOAD_T || state_nx == LOAD_O);
      en         <= (state_nx == RUN);
      cooking    <= (state_nx == RUN);
      done       <= (state_nx == DONE_ST);
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_keypad_loader.sv
// tb_keypad_loader
//   Scoreboard bench for keypad_loader: each driven cycle pushes the outputs a
//   behavioural model predicts; a negedge monitor pops and compares them.
module tb_keypad_loader;

  localparam int DONE_CYCLES = 3;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       door_closed = 1'b1;
  logic       zero = 1'b0;
  logic [3:0] data;
  logic       loadn, en, cooking, done, err;
  logic [3:0] entry_mins, entry_tens, entry_ones;

  keypad_loader #(.DONE_CYCLES(DONE_CYCLES)) dut (
    .clock(clock), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .door_closed(door_closed), .zero(zero), .data(data), .loadn(loadn), .en(en),
    .entry_mins(entry_mins), .entry_tens(entry_tens), .entry_ones(entry_ones),
    .cooking(cooking), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  int md = M_IDLE;
  int em = 0, et = 0, eo = 0;
  int lq[$];          // digits still to be sent to the timer
  int dleft = 0;      // done cycles remaining
  bit merr = 0;

  logic [20:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit door   = 1'b1;

  task automatic model_step(input bit clr, input bit kv, input int kc,
                            input bit dr, input bit z);
    bit is_d, is_s, is_p;
    is_d = kv && kc <= 9;
    is_s = kv && kc == 10;
    is_p = kv && kc == 11;
    merr = 0;
    if (clr) begin
      md = M_IDLE; em = 0; et = 0; eo = 0; lq.delete(); dleft = 0;
      return;
    end
    case (md)
      M_IDLE: begin
        if (is_d) begin em = et; et = eo; eo = kc; end
        else if (is_s) begin
          if (dr && et <= 5 && (em * 100 + et * 10 + eo) != 0) begin
            lq = '{em, et, eo};
            md = M_LOAD;
          end else merr = 1;
        end else if (is_p) begin em = 0; et = 0; eo = 0; end
      end
      M_LOAD: begin
        void'(lq.pop_front());
        if (lq.size() == 0) md = M_RUN;
      end
      M_RUN: begin
        if (z) begin md = M_DONE; dleft = DONE_CYCLES; end
        else if (is_p || !dr) md = M_PAUSE;
      end
      M_PAUSE: begin
        if (is_s && dr) md = M_RUN;
        else if (is_p) begin md = M_IDLE; em = 0; et = 0; eo = 0; end
      end
      default: begin
        dleft--;
        if (dleft == 0) begin md = M_IDLE; em = 0; et = 0; eo = 0; end
      end
    endcase
  endtask

  function automatic logic [20:0] model_out();
    logic [3:0] d;
    d = (md == M_LOAD) ? 4'(lq[0]) : 4'd0;
    return {d, (md != M_LOAD), (md == M_RUN), 4'(em), 4'(et), 4'(eo),
            (md == M_RUN), (md == M_DONE), merr};
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input bit clr, input bit kv, input logic [3:0] kc,
                       input bit dr, input bit z);
    clear = clr; key_valid = kv; key_code = kc; door_closed = dr; zero = z;
    model_step(clr, kv, int'(kc), dr, z);
    @(posedge clock);
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic press(input logic [3:0] k);
    drive(1'b0, 1'b1, k, door, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, door, 1'b0);
  endtask

  // ---------------- monitor ----------------
  logic [20:0] act, expv;
  always @(negedge clock) begin
    cyc++;
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      act  = {data, loadn, en, entry_mins, entry_tens, entry_ones, cooking, done, err};
      checks++;
      if (act !== expv) begin
        fails++;
        $display("FAIL outputs cyc %0d: got data=%0d loadn=%b en=%b entry=%0d:%0d%0d cook=%b done=%b err=%b, want data=%0d loadn=%b en=%b entry=%0d:%0d%0d cook=%b done=%b err=%b",
                 cyc, act[20:17], act[16], act[15], act[14:11], act[10:7], act[6:3],
                 act[2], act[1], act[0], expv[20:17], expv[16], expv[15],
                 expv[14:11], expv[10:7], expv[6:3], expv[2], expv[1], expv[0]);
      end
    end
  end

  initial begin
    int r;
    logic [3:0] kc;
    bit kv, clr, z;
    // reset
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    // 8:57 entry, start, load, run
    press(4'd8); press(4'd5); press(4'd7); press(4'd10);
    tick(4);
    // door open pauses, resume without reload, stop twice
    door = 1'b0; tick(1);
    door = 1'b1; press(4'd10); tick(2);
    press(4'd11); press(4'd11); tick(1);
    // 1,2,3,4 -> 2:34 then Stop clears
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd11);
    // rejected starts: 1:75, 0:00, 1:00 with door open
    press(4'd1); press(4'd7); press(4'd5); press(4'd10); tick(1);
    press(4'd11); press(4'd10); tick(1);
    press(4'd1); press(4'd0); press(4'd0);
    door = 1'b0; press(4'd10); tick(1);
    // 1:00 accepted, then zero together with Stop
    door = 1'b1; press(4'd10); tick(4);
    drive(1'b0, 1'b1, 4'd11, 1'b1, 1'b1);
    tick(5);
    // clear during LOAD_T
    press(4'd2); press(4'd3); press(4'd0); press(4'd10);
    tick(1);
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    tick(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 199) == 0);
      kv  = ($urandom_range(0, 2) == 0);
      r   = $urandom_range(0, 99);
      if (r < 60)      kc = 4'($urandom_range(0, 9));
      else if (r < 80) kc = 4'd10;
      else if (r < 95) kc = 4'd11;
      else             kc = 4'($urandom_range(12, 15));
      door = ($urandom_range(0, 19) != 0);
      z    = ($urandom_range(0, 24) == 0);
      drive(clr, kv, kc, door, z);
    end
    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
